// File: rtl/pdm_capture_pkg.sv
// Shared constants and width helpers for the PDM capture path.
// The CIC order is fixed at 3; the helpers derive accumulator width and output scaling.
package pdm_capture_pkg;

    localparam int CIC_ORDER     = 3;
    localparam int DEFAULT_OUT_W = 16;

    // Bit growth of an order-N CIC is N*log2(DECIM); one extra bit for sign, one for headroom.
    function automatic int acc_width(input int decim);
        return CIC_ORDER * $clog2(decim) + 2;
    endfunction

    function automatic int scale_shift(input int decim, input int out_w);
        return CIC_ORDER * $clog2(decim) + 1 - out_w;
    endfunction

endpackage

// File: rtl/cic3_decim.sv
// Third-order CIC decimator: one update per taken PDM bit, one PCM result per DECIM bits.
// The first three comb results after reset or enable are discarded while the filter fills.
module cic3_decim
    import pdm_capture_pkg::*;
#(
    parameter int DECIM = 64,
    parameter int OUT_W = DEFAULT_OUT_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    bit_in,
    input  logic                    bit_stb,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    sample_stb
);

    localparam int L     = $clog2(DECIM);
    localparam int ACC_W = acc_width(DECIM);
    localparam int SHIFT = scale_shift(DECIM, OUT_W);
    localparam int SCL_W = ACC_W - SHIFT;
    localparam logic signed [SCL_W-1:0] SMAX = SCL_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SCL_W-1:0] SMIN = SCL_W'(-(2 ** (OUT_W - 1)));

    logic signed [ACC_W-1:0] x, i1, i2, i3, i1n, i2n, i3n;
    logic signed [ACC_W-1:0] d1, d2, d3, c1, c2, c3;
    logic signed [SCL_W-1:0] scaled;
    logic signed [OUT_W-1:0] sat;
    logic [L-1:0]            bit_cnt;
    logic [1:0]              disc_cnt;
    logic                    frame_end;

    // Integrators are unpipelined so the combs see the value including the current bit.
    always_comb begin
        x         = {{(ACC_W-1){~bit_in}}, 1'b1};
        i1n       = i1 + x;
        i2n       = i2 + i1n;
        i3n       = i3 + i2n;
        c1        = i3n - d1;
        c2        = c1 - d2;
        c3        = c2 - d3;
        frame_end = bit_stb && (bit_cnt == L'(DECIM - 1));
        scaled    = c3[ACC_W-1:SHIFT];
        if (scaled > SMAX) begin
            sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (scaled < SMIN) begin
            sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat = scaled[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || !enable) begin
            i1         <= '0;
            i2         <= '0;
            i3         <= '0;
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            bit_cnt    <= '0;
            disc_cnt   <= '0;
            sample_out <= '0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            if (bit_stb) begin
                i1      <= i1n;
                i2      <= i2n;
                i3      <= i3n;
                bit_cnt <= bit_cnt + L'(1);
                if (frame_end) begin
                    d1 <= i3n;
                    d2 <= c1;
                    d3 <= c2;
                    if (disc_cnt == 2'd3) begin
                        sample_out <= sat;
                        sample_stb <= 1'b1;
                    end else begin
                        disc_cnt <= disc_cnt + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pdm_capture.sv
// PDM microphone front end: bit-clock divider, input synchroniser, CIC decimator and a
// single-entry valid/ready output register with sticky overrun flag.
module pdm_capture
    import pdm_capture_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DECIM   = 64,
    parameter int OUT_W   = DEFAULT_OUT_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    output logic                    pdm_clk,
    input  logic                    pdm_dat,
    output logic signed [OUT_W-1:0] sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    input  logic                    clear_overrun
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0]        div_cnt, div_next;
    logic [1:0]              sync;
    logic                    bit_stb;
    logic                    accept;
    logic signed [OUT_W-1:0] cic_sample;
    logic                    cic_stb;

    // A bit is taken as the high phase ends, when the mic output has long been stable.
    always_comb begin
        bit_stb  = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
        div_next = bit_stb ? '0 : div_cnt + DIV_W'(1);
        accept   = !sample_valid || sample_ready;
    end

    // pdm_clk is registered from the next count so the mic sees a glitch-free clock.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
            sync    <= '0;
        end else begin
            sync <= {sync[0], pdm_dat};
            if (!enable) begin
                div_cnt <= '0;
                pdm_clk <= 1'b0;
            end else begin
                div_cnt <= div_next;
                pdm_clk <= (div_next >= DIV_W'(CLK_DIV / 2));
            end
        end
    end

    cic3_decim #(
        .DECIM (DECIM),
        .OUT_W (OUT_W)
    ) u_cic (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .bit_in     (sync[1]),
        .bit_stb    (bit_stb),
        .sample_out (cic_sample),
        .sample_stb (cic_stb)
    );

    // An unconsumed sample is never overwritten; a consumer taking it this cycle frees the slot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (cic_stb && accept) begin
                sample       <= cic_sample;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (cic_stb && !accept) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_capture.sv
// Bench for pdm_capture: table of constant/alternating input patterns with a scoreboard,
// plus hand sequences for clocking, back-pressure, same-cycle handshake and mid-frame reset.
`timescale 1ns/1ps
module tb_pdm_capture;

    localparam int CLK_DIV   = 4;
    localparam int DECIM     = 64;
    localparam int OUT_W     = 16;
    localparam int PERIOD    = CLK_DIV * DECIM;
    localparam int FIRST_LAT = 4 * PERIOD;
    localparam int LAT_TOL   = 8;

    typedef enum logic [1:0] {PAT_ONE, PAT_ZERO, PAT_ALT} pat_t;
    typedef struct {
        pat_t                    pat;
        int                      nsamp;
        logic signed [OUT_W-1:0] expected;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    enable = 1'b0;
    logic                    pdm_clk;
    logic                    pdm_dat = 1'b0;
    logic signed [OUT_W-1:0] sample;
    logic                    sample_valid;
    logic                    sample_ready = 1'b0;
    logic                    overrun;
    logic                    clear_overrun = 1'b0;
    pat_t                    pat = PAT_ZERO;

    int                      vectors = 0;
    int                      miscompares = 0;
    logic signed [OUT_W-1:0] sb_q[$];
    vec_t                    vecs[4];

    pdm_capture #(
        .CLK_DIV (CLK_DIV),
        .DECIM   (DECIM),
        .OUT_W   (OUT_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .pdm_clk       (pdm_clk),
        .pdm_dat       (pdm_dat),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    // Microphone model: new data shortly after each falling edge of the bit clock.
    initial begin
        forever begin
            @(negedge pdm_clk);
            #1;
            case (pat)
                PAT_ONE:  pdm_dat = 1'b1;
                PAT_ZERO: pdm_dat = 1'b0;
                default:  pdm_dat = ~pdm_dat;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    task automatic checkLatency(input string name, input int actual);
        vectors++;
        if (actual < FIRST_LAT - LAT_TOL || actual > FIRST_LAT + LAT_TOL) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d cycles, wanted %0d..%0d", name, actual,
                     FIRST_LAT - LAT_TOL, FIRST_LAT + LAT_TOL);
        end
    endtask

    task automatic failNote(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got no sample_valid, wanted one within budget", name);
    endtask

    task automatic waitValid(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reset, select the input pattern and leave capture running from the next edge.
    task automatic applyStimulus(input pat_t p, input logic rdy);
        @(negedge clk);
        resetn        = 1'b0;
        enable        = 1'b0;
        clear_overrun = 1'b0;
        sample_ready  = rdy;
        pat           = p;
        tick(2);
        resetn = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        int cyc;
        bit ok;
        bit saw_high;
        logic signed [OUT_W-1:0] exp_v;

        $display("[TB] start");

        vecs[0] = '{PAT_ONE,  3, 16'sh7FFF};
        vecs[1] = '{PAT_ZERO, 3, 16'sh8000};
        vecs[2] = '{PAT_ALT,  3, 16'sh0000};
        vecs[3] = '{PAT_ONE,  2, 16'sh7FFF};

        // Reset values and bit-clock waveform
        @(negedge clk);
        resetn = 1'b0;
        enable = 1'b1;
        tick(2);
        checkOutput("rst_sample", sample, 0);
        checkOutput("rst_valid", sample_valid, 0);
        checkOutput("rst_overrun", overrun, 0);
        resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkOutput("pdm_clk_wave", pdm_clk, (k % 4) >= 2);
            tick(1);
        end

        // Table-driven patterns, consumer always ready
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].pat, 1'b1);
            for (int s = 0; s < vecs[i].nsamp; s++) sb_q.push_back(vecs[i].expected);
            for (int s = 0; s < vecs[i].nsamp; s++) begin
                waitValid(s == 0 ? FIRST_LAT + LAT_TOL : PERIOD + LAT_TOL, cyc, ok);
                if (!ok) begin
                    failNote("table_wait");
                    break;
                end
                if (s == 0) checkLatency("first_latency", cyc);
                else checkOutput("sample_interval", cyc, PERIOD);
                exp_v = sb_q.pop_front();
                checkOutput("table_sample", sample, exp_v);
            end
            sb_q.delete();
        end

        // Back-pressure across two periods, then idle and overrun clear
        applyStimulus(PAT_ONE, 1'b0);
        waitValid(FIRST_LAT + LAT_TOL, cyc, ok);
        if (!ok) failNote("bp_wait");
        pat = PAT_ZERO;
        checkOutput("bp_first", sample, 16'sh7FFF);
        checkOutput("bp_overrun_early", overrun, 0);
        tick(2 * PERIOD + 10);
        checkOutput("bp_valid_held", sample_valid, 1);
        checkOutput("bp_sample_held", sample, 16'sh7FFF);
        checkOutput("bp_overrun_set", overrun, 1);
        enable = 1'b0;
        tick(1);
        saw_high = pdm_clk;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            saw_high = saw_high | pdm_clk;
        end
        checkOutput("idle_pdm_clk_low", saw_high, 0);
        checkOutput("idle_valid_kept", sample_valid, 1);
        checkOutput("idle_sample_kept", sample, 16'sh7FFF);
        checkOutput("idle_overrun_kept", overrun, 1);
        clear_overrun = 1'b1;
        tick(1);
        clear_overrun = 1'b0;
        checkOutput("overrun_cleared", overrun, 0);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        checkOutput("handshake_drops_valid", sample_valid, 0);

        // Ready asserted exactly in the cycle a new sample arrives
        applyStimulus(PAT_ONE, 1'b0);
        waitValid(FIRST_LAT + LAT_TOL, cyc, ok);
        if (!ok) failNote("same_cycle_wait");
        tick(PERIOD - 1);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        checkOutput("same_cycle_valid", sample_valid, 1);
        checkOutput("same_cycle_overrun", overrun, 0);
        checkOutput("same_cycle_sample", sample, 16'sh7FFF);

        // Reset pulse about 30 bits into a frame
        applyStimulus(PAT_ONE, 1'b0);
        waitValid(FIRST_LAT + LAT_TOL, cyc, ok);
        if (!ok) failNote("midrst_wait");
        tick(30 * CLK_DIV);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        checkOutput("midrst_pdm_clk", pdm_clk, 0);
        checkOutput("midrst_sample", sample, 0);
        checkOutput("midrst_valid", sample_valid, 0);
        checkOutput("midrst_overrun", overrun, 0);
        sample_ready = 1'b1;
        waitValid(FIRST_LAT + LAT_TOL, cyc, ok);
        if (!ok) failNote("midrst_resume_wait");
        else begin
            checkLatency("midrst_latency", cyc);
            checkOutput("midrst_resume_sample", sample, 16'sh7FFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
